// File: rtl/pipelined_datapath_pkg.sv
// Shared types and defaults for the two-stage load/store/ALU datapath.
package pipelined_datapath_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_NUM_REGS   = 16;
    localparam int DEF_DMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_ALU   = 2'd3
    } op_kind_e;

    typedef enum logic [2:0] {
        ALU_ZERO = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_AND  = 3'd5,
        ALU_INC  = 3'd6,
        ALU_PASS = 3'd7
    } alu_sel_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/pipelined_datapath_reg_file.sv
// Register file: two combinational read ports, one synchronous write port.
module reg_file
    import pipelined_datapath_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [RA_W-1:0]   ra,
    input  logic [RA_W-1:0]   rb,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage is not reset; the top sweeps zeros in after reset.
    always_ff @(posedge clk) begin
        if (we) regs[wa] <= wd;
    end

    assign rd_a = regs[ra];
    assign rd_b = regs[rb];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage datapath: accept edge captures operands into EX, next edge commits
// the register or memory write. Clears the register file after every reset.
module pipelined_datapath
    import pipelined_datapath_pkg::*;
#(
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    parameter int  DMEM_DEPTH = DEF_DMEM_DEPTH,
    localparam int RA_W       = $clog2(NUM_REGS),
    localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_kind,
    input  logic [2:0]        alu_sel,
    input  logic [DA_W-1:0]   d_addr,
    input  logic [RA_W-1:0]   w_addr,
    input  logic [RA_W-1:0]   ra_addr,
    input  logic [RA_W-1:0]   rb_addr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    typedef struct packed {
        op_kind_e        kind;
        alu_sel_e        sel;
        logic [RA_W-1:0] wa;
        logic [DA_W-1:0] da;
    } ex_t;

    state_e            state;
    logic [RA_W-1:0]   clr_cnt;
    ex_t               ex;
    logic              accept;
    logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] mem [DMEM_DEPTH];
    logic              rf_we;
    logic [RA_W-1:0]   rf_wa;
    logic [DATA_W-1:0] rf_wd;

    assign accept = op_valid & op_ready;

    assign wb_valid = (ex.kind == OP_LOAD) || (ex.kind == OP_ALU);
    assign wb_addr  = ex.wa;
    assign wb_data  = (ex.kind == OP_LOAD) ? mem_q : alu_out;

    // The EX write lands on the same edge the next op samples the file.
    assign fwd_a = (wb_valid && wb_addr == ra_addr) ? wb_data : rf_a;
    assign fwd_b = (wb_valid && wb_addr == rb_addr) ? wb_data : rf_b;

    assign rf_we = (state == ST_CLEAR) || wb_valid;
    assign rf_wa = (state == ST_CLEAR) ? clr_cnt : wb_addr;
    assign rf_wd = (state == ST_CLEAR) ? '0 : wb_data;

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk  (clk),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd),
        .ra   (ra_addr),
        .rb   (rb_addr),
        .rd_a (rf_a),
        .rd_b (rf_b)
    );

    always_comb begin
        alu_out = '0;
        case (ex.sel)
            ALU_ZERO: alu_out = '0;
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_INC:  alu_out = alu_a + DATA_W'(1);
            ALU_PASS: alu_out = alu_a;
            default:  alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            op_ready <= 1'b0;
            ex       <= '{kind: OP_NOP, sel: ALU_ZERO, wa: '0, da: '0};
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + RA_W'(1);
                    if (clr_cnt == RA_W'(NUM_REGS - 1)) begin
                        state    <= ST_RUN;
                        op_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ex    <= '{kind: op_kind_e'(op_kind), sel: alu_sel_e'(alu_sel),
                                   wa: w_addr, da: d_addr};
                        alu_a <= fwd_a;
                        alu_b <= fwd_b;
                    end else begin
                        // Bubble: operands and select hold so alu_out is stable.
                        ex.kind <= OP_NOP;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Memory is left unreset so it maps onto block RAM; reads are write-first.
    always_ff @(posedge clk) begin
        if (ex.kind == OP_STORE) mem[ex.da] <= alu_a;
        if (accept)
            mem_q <= (ex.kind == OP_STORE && ex.da == d_addr) ? alu_a : mem[d_addr];
    end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench: driver pushes expected EX-stage results, monitor pops on accept.
module tb_pipelined_datapath;

    localparam logic [1:0] K_NOP = 2'd0, K_LD = 2'd1, K_ST = 2'd2, K_ALU = 2'd3;
    localparam logic [2:0] S_ZERO = 3'd0, S_ADD = 3'd1, S_SUB = 3'd2, S_XOR = 3'd3,
                           S_OR = 3'd4, S_AND = 3'd5, S_INC = 3'd6, S_PASS = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_kind = 2'd0;
    logic [2:0]  alu_sel = 3'd0;
    logic [7:0]  d_addr = 8'd0;
    logic [3:0]  w_addr = 4'd0, ra_addr = 4'd0, rb_addr = 4'd0;
    logic [15:0] alu_a, alu_b, alu_out, wb_data;
    logic        wb_valid;
    logic [3:0]  wb_addr;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        wb;
        logic [3:0]  wa;
        logic [15:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pipelined_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_kind  (op_kind),
        .alu_sel  (alu_sel),
        .d_addr   (d_addr),
        .w_addr   (w_addr),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: an accept seen at a rising edge means EX outputs are checked at the next falling edge.
    initial begin
        logic fire;
        exp_t e;
        forever begin
            @(posedge clk);
            fire = op_valid && op_ready && !rst;
            @(negedge clk);
            if (!rst) begin
                if (fire) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: accept with no expectation at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("alu_out", alu_out, e.o);
                        chk("wb_valid", wb_valid, e.wb);
                        if (e.wb) begin
                            chk("wb_addr", wb_addr, e.wa);
                            chk("wb_data", wb_data, e.wd);
                        end
                    end
                end else begin
                    chk("wb_idle", wb_valid, 1'b0);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] k, input logic [2:0] s, input logic [3:0] wa,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [7:0] da,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] eo,
                         input logic ewb, input logic [15:0] ewd);
        int n = 0;
        op_valid = 1'b1;
        op_kind  = k;
        alu_sel  = s;
        w_addr   = wa;
        ra_addr  = ra;
        rb_addr  = rb;
        d_addr   = da;
        sb.push_back('{a: ea, b: eb, o: eo, wb: ewb, wa: wa, wd: ewd});
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("accept_timeout", op_ready, 1'b1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Counts rising edges with op_ready low, starting at the reset-release falling edge.
    task automatic count_not_ready(input string nm);
        int cnt = 0;
        while (!op_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk(nm, cnt, 16);
    endtask

    // Builds a constant in register r from zero by doubling and incrementing (R15 stays zero).
    task automatic build(input logic [3:0] r, input logic [15:0] v);
        logic [15:0] x = 16'h0;
        issue(K_ALU, S_ZERO, r, 4'd15, 4'd15, 8'h00, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0);
        for (int i = 15; i >= 0; i--) begin
            issue(K_ALU, S_ADD, r, r, r, 8'h00, x, x, x + x, 1'b1, x + x);
            x = x + x;
            if (v[i]) begin
                issue(K_ALU, S_INC, r, r, 4'd15, 8'h00, x, 16'h0, x + 16'h1, 1'b1, x + 16'h1);
                x = x + 16'h1;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_addr", wb_addr, 4'h0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_alu_a", alu_a, 16'h0);
        chk("rst_alu_b", alu_b, 16'h0);
        chk("rst_alu_out", alu_out, 16'h0);
        rst = 1'b0;
        count_not_ready("clear_cycles");

        for (int r = 0; r < 16; r++)
            issue(K_ALU, S_PASS, 4'(r), 4'(r), 4'(r), 8'h00, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0);

        build(4'd8, 16'h10AC);
        build(4'd9, 16'hCC05);
        issue(K_ST, S_ZERO, 4'd0, 4'd8, 4'd15, 8'h06, 16'h10AC, 16'h0, 16'h0, 1'b0, 16'h0);
        issue(K_ST, S_ZERO, 4'd0, 4'd9, 4'd15, 8'h0B, 16'hCC05, 16'h0, 16'h0, 1'b0, 16'h0);
        issue(K_LD, S_ZERO, 4'd0, 4'd15, 4'd15, 8'h06, 16'h0, 16'h0, 16'h0, 1'b1, 16'h10AC);
        issue(K_LD, S_ZERO, 4'd1, 4'd15, 4'd15, 8'h0B, 16'h0, 16'h0, 16'h0, 1'b1, 16'hCC05);
        issue(K_ALU, S_ADD, 4'd2, 4'd0, 4'd1, 8'h00, 16'h10AC, 16'hCC05, 16'hDCB1, 1'b1, 16'hDCB1);
        issue(K_ALU, S_INC, 4'd3, 4'd2, 4'd15, 8'h00, 16'hDCB1, 16'h0, 16'hDCB2, 1'b1, 16'hDCB2);
        issue(K_ALU, S_ADD, 4'd4, 4'd3, 4'd3, 8'h00, 16'hDCB2, 16'hDCB2, 16'hB964, 1'b1, 16'hB964);
        issue(K_ST, S_ZERO, 4'd0, 4'd2, 4'd15, 8'h00, 16'hDCB1, 16'h0, 16'h0, 1'b0, 16'h0);
        issue(K_LD, S_ZERO, 4'd5, 4'd15, 4'd15, 8'h00, 16'h0, 16'h0, 16'h0, 1'b1, 16'hDCB1);
        issue(K_ALU, S_INC, 4'd6, 4'd15, 4'd15, 8'h00, 16'h0, 16'h0, 16'h1, 1'b1, 16'h1);
        issue(K_ALU, S_SUB, 4'd7, 4'd15, 4'd6, 8'h00, 16'h0, 16'h1, 16'hFFFF, 1'b1, 16'hFFFF);

        @(posedge clk);
        #1;
        chk("bubble_hold_a", alu_a, 16'h0);
        chk("bubble_hold_b", alu_b, 16'h1);
        chk("bubble_hold_out", alu_out, 16'hFFFF);
        @(negedge clk);

        issue(K_ALU, S_PASS, 4'd10, 4'd7, 4'd15, 8'h00, 16'hFFFF, 16'h0, 16'hFFFF, 1'b1, 16'hFFFF);
        issue(K_ALU, S_XOR, 4'd11, 4'd4, 4'd2, 8'h00, 16'hB964, 16'hDCB1, 16'h65D5, 1'b1, 16'h65D5);
        issue(K_ALU, S_OR, 4'd13, 4'd4, 4'd2, 8'h00, 16'hB964, 16'hDCB1, 16'hFDF5, 1'b1, 16'hFDF5);
        issue(K_ALU, S_AND, 4'd14, 4'd4, 4'd2, 8'h00, 16'hB964, 16'hDCB1, 16'h9820, 1'b1, 16'h9820);
        issue(K_ALU, S_PASS, 4'd12, 4'd5, 4'd15, 8'h00, 16'hDCB1, 16'h0, 16'hDCB1, 1'b1, 16'hDCB1);
        issue(K_NOP, S_PASS, 4'd0, 4'd12, 4'd15, 8'h00, 16'hDCB1, 16'h0, 16'hDCB1, 1'b0, 16'h0);

        // Reset lands while an ALU write to R12 sits in EX.
        issue(K_ALU, S_PASS, 4'd12, 4'd7, 4'd15, 8'h00, 16'hFFFF, 16'h0, 16'hFFFF, 1'b1, 16'hFFFF);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_op_ready", op_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_r12_kept", dut.u_rf.regs[12], 16'hDCB1);
        @(negedge clk);
        rst = 1'b0;
        count_not_ready("reclear_cycles");
        issue(K_ALU, S_PASS, 4'd12, 4'd12, 4'd15, 8'h00, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0);
        issue(K_ALU, S_ADD, 4'd3, 4'd7, 4'd4, 8'h00, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
